multicycle_ctrl_unit: RTL and testbench
=======================================

Name: multicycle_ctrl_unit

Overview:
- Parametrised multi-cycle successor to the combinational opcode decoder.
- Sequences each instruction through FETCH/DECODE/EXEC/MEM/WB states and drives the same datapath controls (Jmp, MemRead, MemtoReg, MemWrite, ALUsrc, RegWrite, ALUop), plus PCWrite/IRWrite strobes.
- Adds a memory ready handshake with timeout, a pipeline-style stall, an illegal-opcode trap and a retired-instruction counter.
- Sits between the instruction register and the datapath of the CPU core.

Parameters:
- OPCODE_W, 3, opcode width; codes at or above 6 are illegal.
- ALUOP_W, 2, ALUop width (>=1); 0 = add, 1 = sub, other codes reserved.
- MEM_TIMEOUT, 8, maximum wait cycles for mem_ready before error (>=2).
- CNT_W, 16, width of the retired-instruction counter.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- opcode  in  OPCODE_W  opcode from IR; sampled in DECODE only.
- mem_ready  in  1  memory completes the current access this cycle.
- stall  in  1  freeze request from hazard logic.
- Jmp, MemRead, MemtoReg, MemWrite, ALUsrc, RegWrite  out  1 each  datapath controls.
- ALUop  out  ALUOP_W  ALU operation select.
- PCWrite  out  1  PC update strobe.
- IRWrite  out  1  instruction register load strobe.
- illegal  out  1  one-cycle pulse on illegal opcode.
- mem_err  out  1  one-cycle pulse on memory timeout.
- instr_done  out  1  one-cycle pulse on the final cycle of a retired instruction.
- instr_count  out  CNT_W  retired instructions, wraps to 0.

Behaviour:
- Reset (rst_n=0, async):
  - state=FETCH; opcode latch, wait counter and instr_count clear to 0.
  - All outputs forced to 0 while rst_n=0, regardless of state.
  - Reset mid-instruction abandons it; no strobe is issued.
- States: FETCH, DECODE, EXEC, MEM, WB, TRAP, ERR. Outputs are combinational from state, the latched opcode, mem_ready and stall.
- FETCH:
  - MemRead=1.
  - On mem_ready: IRWrite=1, PCWrite=1, go to DECODE.
  - Otherwise the wait counter increments. When it equals MEM_TIMEOUT-1 without ready, go to ERR.
- DECODE:
  - Latch opcode.
  - 010 (j): Jmp=1, PCWrite=1, instr_done=1, go to FETCH.
  - Code >=6: go to TRAP.
  - Otherwise go to EXEC.
- EXEC:
  - ALUsrc=1 for lw/sw/addi, 0 for add/sub.
  - ALUop=1 for sub, 0 otherwise.
  - lw/sw go to MEM; add/sub/addi go to WB.
- MEM:
  - lw: MemRead=1. sw: MemWrite=1.
  - ALUsrc and ALUop held as in EXEC.
  - Same mem_ready/timeout rule as FETCH.
  - On ready: lw goes to WB; sw asserts instr_done and goes to FETCH.
- WB:
  - RegWrite=1, instr_done=1.
  - MemtoReg=1 for lw, 0 otherwise.
  - Go to FETCH.
- TRAP: illegal=1 for one cycle, go to FETCH; not counted as retired.
- ERR: mem_err=1 for one cycle, go to FETCH; not counted as retired.
- Wait counter: cleared on every state change; reaching the limit gives exactly MEM_TIMEOUT waiting cycles.
- Cycle counts with mem_ready=1 at first request: j=2, add/sub/addi=4, sw=4, lw=5.
- stall=1 in any state:
  - State, opcode latch and wait counter all hold.
  - PCWrite, IRWrite, RegWrite, MemWrite, MemRead, instr_done, illegal and mem_err are forced to 0.
  - Jmp, MemtoReg, ALUsrc and ALUop keep their state values.
- stall and mem_ready high together: stall wins; the ready is ignored and must be re-presented.
- instr_count increments by 1 on each instr_done cycle and wraps from all-ones to 0.
- Idle (unused) outputs read 0.

Test Plan:
- Reset, then add (011), mem_ready tied to 1:
  - FETCH→DECODE→EXEC→WB.
  - RegWrite=1 only in cycle 4; ALUop=0, ALUsrc=0.
  - instr_count=1.
- lw (000) with mem_ready delayed 3 cycles in MEM:
  - MemRead held for 4 MEM cycles, then WB with MemtoReg=1, RegWrite=1.
  - Total 8 cycles; no mem_err.
- FETCH with mem_ready stuck at 0, MEM_TIMEOUT=8:
  - mem_err pulses exactly once, 8 cycles after entering FETCH.
  - FSM returns to FETCH; instr_count unchanged.
- Opcode 110:
  - illegal pulses in cycle 3; no RegWrite, MemWrite or PCWrite beyond the fetch strobe.
  - The next fetch follows.
- sub (101) with stall=1 for 2 cycles in EXEC while mem_ready=1:
  - ALUop=1 is held through the stall; WB occurs 2 cycles late.
  - instr_count is preset to all-ones via a run of j instructions, and wraps to 0 on this retire.
- Async rst_n low mid-MEM of a sw:
  - All outputs go to 0 immediately with no MemWrite.
  - After release the FSM is in FETCH and instr_count=0.

Source files
------------

// File: rtl/multicycle_ctrl_unit_if.sv
// Control bundle between the multi-cycle control unit and the datapath/IR.
// The master side is the control unit; the slave side is the datapath/IR/memory.
interface multicycle_ctrl_unit_if #(
    parameter int OPCODE_W = 3,
    parameter int ALUOP_W  = 2,
    parameter int CNT_W    = 16
);
    logic [OPCODE_W-1:0] opcode;
    logic                mem_ready;
    logic                stall;
    logic                Jmp;
    logic                MemRead;
    logic                MemtoReg;
    logic                MemWrite;
    logic                ALUsrc;
    logic                RegWrite;
    logic [ALUOP_W-1:0]  ALUop;
    logic                PCWrite;
    logic                IRWrite;
    logic                illegal;
    logic                mem_err;
    logic                instr_done;
    logic [CNT_W-1:0]    instr_count;

    modport master (
        input  opcode, mem_ready, stall,
        output Jmp, MemRead, MemtoReg, MemWrite, ALUsrc, RegWrite, ALUop,
               PCWrite, IRWrite, illegal, mem_err, instr_done, instr_count
    );

    modport slave (
        output opcode, mem_ready, stall,
        input  Jmp, MemRead, MemtoReg, MemWrite, ALUsrc, RegWrite, ALUop,
               PCWrite, IRWrite, illegal, mem_err, instr_done, instr_count
    );
endinterface

// File: rtl/multicycle_ctrl_unit.sv
// Multi-cycle instruction sequencer: FETCH/DECODE/EXEC/MEM/WB with memory
// timeout, stall freeze, illegal-opcode trap and a retired-instruction counter.
//
// state  | meaning
// FETCH  | read instruction memory, load IR and bump PC on ready
// DECODE | latch opcode; jumps retire here
// EXEC   | ALU operation
// MEM    | data memory access for lw/sw
// WB     | register file write-back
// TRAP   | one-cycle illegal-opcode pulse
// ERR    | one-cycle memory-timeout pulse
module multicycle_ctrl_unit #(
    parameter int OPCODE_W    = 3,
    parameter int ALUOP_W     = 2,
    parameter int MEM_TIMEOUT = 8,
    parameter int CNT_W       = 16
) (
    input logic                  clk,
    input logic                  rst_n,
    multicycle_ctrl_unit_if.master bus
);
    localparam int WAIT_W = $clog2(MEM_TIMEOUT);

    // Opcode map: lw=0 sw=1 j=2 add=3 addi=4 sub=5, 6 and above illegal
    localparam logic [OPCODE_W-1:0] OP_LW   = OPCODE_W'(0);
    localparam logic [OPCODE_W-1:0] OP_SW   = OPCODE_W'(1);
    localparam logic [OPCODE_W-1:0] OP_J    = OPCODE_W'(2);
    localparam logic [OPCODE_W-1:0] OP_ADD  = OPCODE_W'(3);
    localparam logic [OPCODE_W-1:0] OP_SUB  = OPCODE_W'(5);
    localparam logic [OPCODE_W-1:0] OP_ILL  = OPCODE_W'(6);

    typedef enum logic [2:0] {
        S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_TRAP, S_ERR
    } state_t;

    state_t              state, state_nx;
    logic [OPCODE_W-1:0] op_q;
    logic [WAIT_W-1:0]   wait_cnt;
    logic [CNT_W-1:0]    instr_cnt;
    logic                wait_last;

    logic                jmp, mem_rd, mem_to_reg, mem_wr, alu_src, reg_wr;
    logic [ALUOP_W-1:0]  alu_op;
    logic                pc_wr, ir_wr, ill, merr, done;

    assign wait_last = (wait_cnt == WAIT_W'(MEM_TIMEOUT - 1));

    always_comb begin
        state_nx   = state;
        jmp        = 1'b0;
        mem_rd     = 1'b0;
        mem_to_reg = 1'b0;
        mem_wr     = 1'b0;
        alu_src    = 1'b0;
        reg_wr     = 1'b0;
        alu_op     = '0;
        pc_wr      = 1'b0;
        ir_wr      = 1'b0;
        ill        = 1'b0;
        merr       = 1'b0;
        done       = 1'b0;
        case (state)
            S_FETCH: begin
                mem_rd = 1'b1;
                if (bus.mem_ready) begin
                    ir_wr    = 1'b1;
                    pc_wr    = 1'b1;
                    state_nx = S_DECODE;
                end else if (wait_last) begin
                    state_nx = S_ERR;
                end
            end
            S_DECODE: begin
                if (bus.opcode == OP_J) begin
                    jmp      = 1'b1;
                    pc_wr    = 1'b1;
                    done     = 1'b1;
                    state_nx = S_FETCH;
                end else if (bus.opcode >= OP_ILL) begin
                    state_nx = S_TRAP;
                end else begin
                    state_nx = S_EXEC;
                end
            end
            S_EXEC: begin
                alu_src  = (op_q != OP_ADD) && (op_q != OP_SUB);
                alu_op   = (op_q == OP_SUB) ? ALUOP_W'(1) : '0;
                state_nx = (op_q == OP_LW || op_q == OP_SW) ? S_MEM : S_WB;
            end
            S_MEM: begin
                alu_src = 1'b1;
                mem_rd  = (op_q == OP_LW);
                mem_wr  = (op_q == OP_SW);
                if (bus.mem_ready) begin
                    if (op_q == OP_LW) begin
                        state_nx = S_WB;
                    end else begin
                        done     = 1'b1;
                        state_nx = S_FETCH;
                    end
                end else if (wait_last) begin
                    state_nx = S_ERR;
                end
            end
            S_WB: begin
                reg_wr     = 1'b1;
                done       = 1'b1;
                mem_to_reg = (op_q == OP_LW);
                state_nx   = S_FETCH;
            end
            S_TRAP: begin
                ill      = 1'b1;
                state_nx = S_FETCH;
            end
            S_ERR: begin
                merr     = 1'b1;
                state_nx = S_FETCH;
            end
            default: state_nx = S_FETCH;
        endcase
        // A stall freezes the FSM and suppresses every strobe, ready included
        if (bus.stall) begin
            state_nx = state;
            pc_wr    = 1'b0;
            ir_wr    = 1'b0;
            reg_wr   = 1'b0;
            mem_wr   = 1'b0;
            mem_rd   = 1'b0;
            done     = 1'b0;
            ill      = 1'b0;
            merr     = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_FETCH;
            op_q      <= '0;
            wait_cnt  <= '0;
            instr_cnt <= '0;
        end else begin
            state <= state_nx;
            if (state == S_DECODE && !bus.stall) begin
                op_q <= bus.opcode;
            end
            if (state_nx != state) begin
                wait_cnt <= '0;
            end else if (!bus.stall && (state == S_FETCH || state == S_MEM)) begin
                wait_cnt <= wait_cnt + WAIT_W'(1);
            end
            if (done) begin
                instr_cnt <= instr_cnt + CNT_W'(1);
            end
        end
    end

    assign bus.Jmp         = rst_n & jmp;
    assign bus.MemRead     = rst_n & mem_rd;
    assign bus.MemtoReg    = rst_n & mem_to_reg;
    assign bus.MemWrite    = rst_n & mem_wr;
    assign bus.ALUsrc      = rst_n & alu_src;
    assign bus.RegWrite    = rst_n & reg_wr;
    assign bus.ALUop       = rst_n ? alu_op : '0;
    assign bus.PCWrite     = rst_n & pc_wr;
    assign bus.IRWrite     = rst_n & ir_wr;
    assign bus.illegal     = rst_n & ill;
    assign bus.mem_err     = rst_n & merr;
    assign bus.instr_done  = rst_n & done;
    assign bus.instr_count = rst_n ? instr_cnt : '0;
endmodule

// File: tb/tb_multicycle_ctrl_unit.sv
// Directed bench for multicycle_ctrl_unit: per-cycle vector table plus
// hand-written stall, counter-wrap and async-reset sequences.
module tb_multicycle_ctrl_unit;
    localparam int CNT_W = 4;

    // Packed control word: {Jmp,MemRead,MemtoReg,MemWrite,ALUsrc,RegWrite,ALUop[1:0],PCWrite,IRWrite,illegal,mem_err,instr_done}
    localparam logic [12:0] J    = 13'h1000;
    localparam logic [12:0] MR   = 13'h0800;
    localparam logic [12:0] M2R  = 13'h0400;
    localparam logic [12:0] MW   = 13'h0200;
    localparam logic [12:0] AS   = 13'h0100;
    localparam logic [12:0] RW   = 13'h0080;
    localparam logic [12:0] SUB  = 13'h0020;
    localparam logic [12:0] PCW  = 13'h0010;
    localparam logic [12:0] IRW  = 13'h0008;
    localparam logic [12:0] ILL  = 13'h0004;
    localparam logic [12:0] MERR = 13'h0002;
    localparam logic [12:0] DONE = 13'h0001;
    localparam logic [12:0] FB   = MR | IRW | PCW;

    typedef struct {
        logic [2:0]       op;
        logic             rdy;
        logic             stl;
        logic [12:0]      exp;
        logic [CNT_W-1:0] cnt;
    } vec_t;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;
    int   step_id;
    vec_t vq[$];

    multicycle_ctrl_unit_if #(.OPCODE_W(3), .ALUOP_W(2), .CNT_W(CNT_W)) bus ();

    multicycle_ctrl_unit #(
        .OPCODE_W(3), .ALUOP_W(2), .MEM_TIMEOUT(8), .CNT_W(CNT_W)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [12:0] ctrl_word();
        return {bus.Jmp, bus.MemRead, bus.MemtoReg, bus.MemWrite, bus.ALUsrc,
                bus.RegWrite, bus.ALUop, bus.PCWrite, bus.IRWrite, bus.illegal,
                bus.mem_err, bus.instr_done};
    endfunction

    task automatic check_outputs(input string tag, input logic [12:0] exp,
                                 input logic [CNT_W-1:0] cnt);
        n_checks++;
        if (ctrl_word() !== exp) begin
            n_fail++;
            $display("FAIL %s step%0d ctrl: got %b expected %b", tag, step_id, ctrl_word(), exp);
        end
        n_checks++;
        if (bus.instr_count !== cnt) begin
            n_fail++;
            $display("FAIL %s step%0d instr_count: got %0d expected %0d", tag, step_id,
                     bus.instr_count, cnt);
        end
    endtask

    // Called at a negedge: drive, check mid-low phase, return at the next negedge.
    task automatic step(input string tag, input logic [2:0] op, input logic rdy,
                        input logic stl, input logic [12:0] exp, input logic [CNT_W-1:0] cnt);
        bus.opcode    = op;
        bus.mem_ready = rdy;
        bus.stall     = stl;
        #1;
        check_outputs(tag, exp, cnt);
        step_id++;
        @(negedge clk);
    endtask

    task automatic push_vec(input logic [2:0] op, input logic rdy, input logic stl,
                            input logic [12:0] exp, input logic [CNT_W-1:0] cnt);
        vq.push_back('{op, rdy, stl, exp, cnt});
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        step_id  = 0;

        // add: F D E WB
        push_vec(3'b011, 1'b1, 1'b0, FB, 0);
        push_vec(3'b011, 1'b1, 1'b0, 13'h0, 0);
        push_vec(3'b011, 1'b1, 1'b0, 13'h0, 0);
        push_vec(3'b011, 1'b1, 1'b0, RW | DONE, 0);
        // lw with ready late by 3 cycles in MEM
        push_vec(3'b000, 1'b1, 1'b0, FB, 1);
        push_vec(3'b000, 1'b1, 1'b0, 13'h0, 1);
        push_vec(3'b000, 1'b1, 1'b0, AS, 1);
        for (int i = 0; i < 3; i++) push_vec(3'b000, 1'b0, 1'b0, MR | AS, 1);
        push_vec(3'b000, 1'b1, 1'b0, MR | AS, 1);
        push_vec(3'b000, 1'b1, 1'b0, RW | M2R | DONE, 1);
        // sw
        push_vec(3'b001, 1'b1, 1'b0, FB, 2);
        push_vec(3'b001, 1'b1, 1'b0, 13'h0, 2);
        push_vec(3'b001, 1'b1, 1'b0, AS, 2);
        push_vec(3'b001, 1'b1, 1'b0, MW | AS | DONE, 2);
        // addi
        push_vec(3'b100, 1'b1, 1'b0, FB, 3);
        push_vec(3'b100, 1'b1, 1'b0, 13'h0, 3);
        push_vec(3'b100, 1'b1, 1'b0, AS, 3);
        push_vec(3'b100, 1'b1, 1'b0, RW | DONE, 3);
        // j
        push_vec(3'b010, 1'b1, 1'b0, FB, 4);
        push_vec(3'b010, 1'b1, 1'b0, J | PCW | DONE, 4);
        // illegal 110: trap in cycle 3, not retired
        push_vec(3'b110, 1'b1, 1'b0, FB, 5);
        push_vec(3'b110, 1'b1, 1'b0, 13'h0, 5);
        push_vec(3'b110, 1'b1, 1'b0, ILL, 5);
        // fetch timeout: 8 waiting cycles, then ERR, then back to FETCH
        for (int i = 0; i < 8; i++) push_vec(3'b110, 1'b0, 1'b0, MR, 5);
        push_vec(3'b110, 1'b0, 1'b0, MERR, 5);
        push_vec(3'b110, 1'b0, 1'b0, MR, 5);
        // stall together with ready in FETCH: ready ignored, re-presented next cycle
        push_vec(3'b010, 1'b1, 1'b1, 13'h0, 5);
        push_vec(3'b010, 1'b1, 1'b0, FB, 5);
        push_vec(3'b010, 1'b1, 1'b0, J | PCW | DONE, 5);

        // reset: outputs all zero even with ready high
        rst_n         = 1'b0;
        bus.opcode    = 3'b011;
        bus.mem_ready = 1'b1;
        bus.stall     = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #1;
        check_outputs("reset", 13'h0, 0);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (vq[i]) step("table", vq[i].op, vq[i].rdy, vq[i].stl, vq[i].exp, vq[i].cnt);

        // bring instr_count to all-ones with jumps (6 -> 15)
        for (int k = 6; k < 15; k++) begin
            step("jrun", 3'b010, 1'b1, 1'b0, FB, CNT_W'(k));
            step("jrun", 3'b010, 1'b1, 1'b0, J | PCW | DONE, CNT_W'(k));
        end

        // sub with a 2-cycle stall in EXEC; retire wraps the counter
        step("sub", 3'b101, 1'b1, 1'b0, FB, 15);
        step("sub", 3'b101, 1'b1, 1'b0, 13'h0, 15);
        step("sub", 3'b101, 1'b1, 1'b1, SUB, 15);
        step("sub", 3'b101, 1'b1, 1'b1, SUB, 15);
        step("sub", 3'b101, 1'b1, 1'b0, SUB, 15);
        step("sub", 3'b101, 1'b1, 1'b0, RW | DONE, 15);
        step("wrap", 3'b101, 1'b0, 1'b0, MR, 0);

        // sw interrupted by async reset while waiting in MEM
        step("swrst", 3'b001, 1'b1, 1'b0, FB, 0);
        step("swrst", 3'b001, 1'b1, 1'b0, 13'h0, 0);
        step("swrst", 3'b001, 1'b1, 1'b0, AS, 0);
        step("swrst", 3'b001, 1'b0, 1'b0, MW | AS, 0);
        bus.mem_ready = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        check_outputs("async_rst", 13'h0, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        step("post_rst", 3'b011, 1'b0, 1'b0, MR, 0);
        step("post_rst", 3'b011, 1'b1, 1'b0, FB, 0);
        step("post_rst", 3'b011, 1'b1, 1'b0, 13'h0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
